// File: rtl/timer_pkg.sv
// Shared definitions for the millisecond timer: register map, bit positions,
// FSM state type and the saturating 64-bit add used for deadlines.
package timer_pkg;

  localparam logic [2:0] ADDR_CTRL   = 3'd0;
  localparam logic [2:0] ADDR_PER_LO = 3'd1;
  localparam logic [2:0] ADDR_PER_HI = 3'd2;
  localparam logic [2:0] ADDR_STATUS = 3'd3;
  localparam logic [2:0] ADDR_NOW_LO = 3'd4;
  localparam logic [2:0] ADDR_NOW_HI = 3'd5;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_PERIODIC = 1;
  localparam int CTRL_IE       = 2;

  localparam int STATUS_PEND  = 0;
  localparam int STATUS_ARMED = 1;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } timer_state_e;

  typedef logic [63:0] ms_t;

  // Clamps to all-ones so a huge period parks the deadline instead of wrapping into the past.
  function automatic ms_t sat_add64(ms_t a, ms_t b);
    logic [64:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[64] ? '1 : sum[63:0];
  endfunction

endpackage

// File: rtl/timer_irq_ctrl.sv
// Programmable ms timer with one-shot/periodic expiry, level interrupt and a
// word-addressed register port including a tear-free 64-bit NOW read.
module timer_irq_ctrl
  import timer_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [63:0] i_ms_count,
  input  logic        i_we,
  input  logic        i_re,
  input  logic [2:0]  i_addr,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_rvalid,
  output logic        o_irq
);

  timer_state_e state_q, state_d;
  logic [2:0]   ctrl_q, ctrl_d;
  ms_t          per_q, per_d;
  ms_t          deadline_q, deadline_d;
  logic         pend_q, pend_d;
  logic [31:0]  shadow_q, shadow_d;
  logic [31:0]  rdata_q, rdata_d;
  logic         rvalid_q, rvalid_d;

  ms_t  per_eff;
  logic expire;
  logic armed;
  logic unused_wdata;

  assign unused_wdata = ^i_wdata[31:3];
  assign per_eff      = (per_q == '0) ? 64'd1 : per_q;
  assign armed        = (state_q == ARMED);
  assign expire       = armed && (i_ms_count >= deadline_q);

  always_comb begin
    state_d    = state_q;
    ctrl_d     = ctrl_q;
    per_d      = per_q;
    deadline_d = deadline_q;
    pend_d     = pend_q;
    shadow_d   = shadow_q;
    rdata_d    = rdata_q;
    rvalid_d   = i_re;

    if (expire) begin
      pend_d = 1'b1;
      if (ctrl_q[CTRL_PERIODIC]) begin
        deadline_d = sat_add64(deadline_q, per_eff);
      end else begin
        state_d         = IDLE;
        ctrl_d[CTRL_EN] = 1'b0;
      end
    end

    // A CTRL write overrides whatever the expiry logic chose for state and deadline.
    if (i_we) begin
      case (i_addr)
        ADDR_CTRL: begin
          ctrl_d = i_wdata[2:0];
          if (i_wdata[CTRL_EN]) begin
            state_d    = ARMED;
            deadline_d = sat_add64(i_ms_count, per_eff);
          end else begin
            state_d = IDLE;
          end
        end
        ADDR_PER_LO: per_d[31:0]  = i_wdata;
        ADDR_PER_HI: per_d[63:32] = i_wdata;
        ADDR_STATUS: begin
          if (i_wdata[STATUS_PEND] && !expire) pend_d = 1'b0;
        end
        default: ;
      endcase
    end

    // Read mux uses only current register values, so a same-cycle write is not visible.
    if (i_re) begin
      case (i_addr)
        ADDR_CTRL:   rdata_d = {29'd0, ctrl_q};
        ADDR_PER_LO: rdata_d = per_q[31:0];
        ADDR_PER_HI: rdata_d = per_q[63:32];
        ADDR_STATUS: rdata_d = {30'd0, armed, pend_q};
        ADDR_NOW_LO: begin
          rdata_d  = i_ms_count[31:0];
          shadow_d = i_ms_count[63:32];
        end
        ADDR_NOW_HI: rdata_d = shadow_q;
        default:     rdata_d = 32'd0;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= IDLE;
      ctrl_q     <= '0;
      per_q      <= '0;
      deadline_q <= '0;
      pend_q     <= 1'b0;
      shadow_q   <= '0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      per_q      <= per_d;
      deadline_q <= deadline_d;
      pend_q     <= pend_d;
      shadow_q   <= shadow_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
    end
  end

  assign o_rdata  = rdata_q;
  assign o_rvalid = rvalid_q;
  assign o_irq    = pend_q & ctrl_q[CTRL_IE];

endmodule

// File: tb/tb_timer_irq_ctrl.sv
// Directed self-checking bench for timer_irq_ctrl with hand-computed expectations.
module tb_timer_irq_ctrl;

  logic        clk;
  logic        rst;
  logic [63:0] ms;
  logic        we;
  logic        re;
  logic [2:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        rvalid;
  logic        irq;

  int checks;
  int failures;

  timer_irq_ctrl dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_ms_count (ms),
    .i_we       (we),
    .i_re       (re),
    .i_addr     (addr),
    .i_wdata    (wdata),
    .o_rdata    (rdata),
    .o_rvalid   (rvalid),
    .o_irq      (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    we = 1'b1; addr = a; wdata = d;
    tick();
    we = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d, output logic v1, output logic v2);
    re = 1'b1; addr = a;
    tick();
    re = 1'b0;
    d  = rdata;
    v1 = rvalid;
    tick();
    v2 = rvalid;
  endtask

  task automatic rd_check(input string tag, input logic [2:0] a, input logic [31:0] exp);
    logic [31:0] d;
    logic v1, v2;
    rd(a, d, v1, v2);
    check_eq(tag, {32'd0, d}, {32'd0, exp});
  endtask

  task automatic step_ms(input logic [63:0] m, input logic exp_irq, input string tag);
    ms = m;
    tick();
    check_eq(tag, {63'd0, irq}, {63'd0, exp_irq});
  endtask

  initial begin
    logic [31:0] d;
    logic v1, v2;
    checks = 0; failures = 0;
    rst = 1'b1; ms = 64'd0; we = 1'b0; re = 1'b0; addr = 3'd0; wdata = 32'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    tick();

    // 1: reset state of every address
    check_eq("rst_irq", {63'd0, irq}, 64'd0);
    check_eq("rst_rvalid", {63'd0, rvalid}, 64'd0);
    for (int a = 0; a < 8; a++) begin
      rd(3'(a), d, v1, v2);
      check_eq($sformatf("rst_rd%0d", a), {32'd0, d}, 64'd0);
      check_eq($sformatf("rst_rv_hi%0d", a), {63'd0, v1}, 64'd1);
      check_eq($sformatf("rst_rv_lo%0d", a), {63'd0, v2}, 64'd0);
    end

    // 2: one-shot PER=5 armed at ms=100
    ms = 64'd100;
    wr(3'd1, 32'd5);
    wr(3'd2, 32'd0);
    wr(3'd0, 32'h5);
    check_eq("os_irq_arm", {63'd0, irq}, 64'd0);
    for (int m = 101; m <= 104; m++) step_ms(64'(m), 1'b0, $sformatf("os_irq_ms%0d", m));
    step_ms(64'd105, 1'b1, "os_irq_ms105");
    rd_check("os_status", 3'd3, 32'h1);
    rd_check("os_ctrl", 3'd0, 32'h4);
    wr(3'd3, 32'h1);
    check_eq("os_w1c_irq", {63'd0, irq}, 64'd0);
    step_ms(64'd106, 1'b0, "os_no_reassert_106");
    step_ms(64'd110, 1'b0, "os_no_reassert_110");

    // 3: periodic PER=3 armed at ms=10
    wr(3'd0, 32'h0);
    wr(3'd1, 32'd3);
    ms = 64'd10;
    wr(3'd0, 32'h7);
    step_ms(64'd11, 1'b0, "per_ms11");
    step_ms(64'd12, 1'b0, "per_ms12");
    step_ms(64'd13, 1'b1, "per_ms13");
    wr(3'd3, 32'h1);
    check_eq("per_w1c13", {63'd0, irq}, 64'd0);
    step_ms(64'd14, 1'b0, "per_ms14");
    step_ms(64'd15, 1'b0, "per_ms15");
    ms = 64'd16;
    wr(3'd3, 32'h1);
    check_eq("per_ms16_w1c_collide", {63'd0, irq}, 64'd1);
    wr(3'd3, 32'h1);
    check_eq("per_w1c16", {63'd0, irq}, 64'd0);
    step_ms(64'd17, 1'b0, "per_ms17");
    step_ms(64'd18, 1'b0, "per_ms18");
    step_ms(64'd19, 1'b1, "per_ms19");
    rd_check("per_status", 3'd3, 32'h3);

    // 4a: PER=0 behaves as 1
    wr(3'd0, 32'h0);
    wr(3'd3, 32'h1);
    wr(3'd1, 32'd0);
    ms = 64'd200;
    wr(3'd0, 32'h5);
    step_ms(64'd200, 1'b0, "per0_ms200");
    step_ms(64'd201, 1'b1, "per0_ms201");
    rd_check("per0_status", 3'd3, 32'h1);

    // 4b: saturating deadline never fires
    wr(3'd0, 32'h0);
    wr(3'd3, 32'h1);
    wr(3'd1, 32'hFFFF_FFFE);
    wr(3'd2, 32'hFFFF_FFFF);
    ms = 64'd10;
    wr(3'd0, 32'h5);
    ms = 64'd1000;
    tick(); tick(); tick();
    check_eq("sat_irq", {63'd0, irq}, 64'd0);
    rd_check("sat_status", 3'd3, 32'h2);
    rd_check("sat_per_hi", 3'd2, 32'hFFFF_FFFF);

    // same-cycle write and read of CTRL returns the old value
    we = 1'b1; re = 1'b1; addr = 3'd0; wdata = 32'h0;
    tick();
    we = 1'b0; re = 1'b0;
    check_eq("rw_same_cycle", {32'd0, rdata}, 64'h5);
    rd_check("rw_after", 3'd0, 32'h0);

    // 5: tear-free NOW snapshot
    ms = 64'h0000_0001_FFFF_FFFF;
    rd_check("snap_lo", 3'd4, 32'hFFFF_FFFF);
    ms = 64'h0000_0002_0000_0000;
    rd_check("snap_hi", 3'd5, 32'h0000_0001);

    // 6: async reset while armed with pend set
    wr(3'd1, 32'd5);
    wr(3'd2, 32'd0);
    ms = 64'd500;
    wr(3'd0, 32'h7);
    step_ms(64'd505, 1'b1, "arst_pre_irq");
    #2 rst = 1'b1;
    #1;
    check_eq("arst_irq_async", {63'd0, irq}, 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    tick();
    rd_check("arst_status", 3'd3, 32'h0);
    rd_check("arst_ctrl", 3'd0, 32'h0);
    check_eq("arst_irq_after", {63'd0, irq}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
